dvi_timing_pattern_gen: RTL and testbench
=========================================

Name: dvi_timing_pattern_gen

Overview:
- Parametrised pixel-domain video timing generator with a built-in test-pattern source.
- Sits between the pixel PLL output and the TMDS encoder/serializer block. Replaces hard-wired 640x480 timing with generic H/V timing, selectable sync polarity and run-time pattern modes.
- Produces hsync/vsync/de, pixel coordinates, frame markers and 24-bit RGB. All outputs are aligned to one another.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync
- CW, 12, width of coordinate counters; must satisfy 2^CW > H_TOTAL and 2^CW > V_TOTAL

Ports:
- pix_clk, input, 1, pixel clock; the only clock
- rst_n, input, 1, synchronous active-low reset
- en, input, 1, run enable
- mode, input, 2, pattern select: 0 = bars, 1 = checker, 2 = gradient, 3 = solid
- solid_rgb, input, 24, colour for mode 3, packed {R,G,B}
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- de, output, 1, data enable (active video)
- x, output, CW, pixel column of the current output pixel
- y, output, CW, line of the current output pixel
- frame_start, output, 1, one-cycle pulse with pixel (0,0)
- frame_cnt, output, 16, completed-frame counter
- rgb, output, 24, pixel colour {R[23:16],G[15:8],B[7:0]}

Behaviour:
- Clock and reset: one clock, pix_clk. Reset is synchronous and active-low on rst_n.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters:
  - h_cnt runs 0..H_TOTAL-1, then wraps to 0 and increments v_cnt.
  - v_cnt runs 0..V_TOTAL-1, then wraps to 0.
- Region decode on the counters:
  - Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines.
- Latency: every output is registered. Outputs in cycle n+1 reflect the counter state in cycle n. All outputs are mutually aligned.
- x/y: equal h_cnt/v_cnt of the pixel presented, including blanking.
- rgb: 0 whenever de=0.
- Reset (rst_n=0 at an edge):
  - Counters go to 0 and frame_cnt to 0.
  - hsync=~HS_POL, vsync=~VS_POL, de=0, frame_start=0, rgb=0, x=y=0.
  - Reset mid-line aborts the frame.
  - The first pixel after release is (0,0), with frame_start.
- en=0:
  - Counters are held at 0 and outputs take their reset values.
  - frame_cnt holds its value.
  - Deasserting en mid-frame takes effect at the next edge.
  - Reasserting en restarts from (0,0) with a frame_start pulse.
- frame_cnt: increments by 1 in the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps modulo 2^16.
- Mode latch: mode and solid_rgb are sampled into an active-mode register only when the counters are at (0,0), i.e. at the frame boundary. A mid-frame change never tears a frame. After reset the active mode is 0.
- Pattern modes (evaluated on the active-mode register):
  - 0 bars: 8 vertical bars in the order white, yellow, cyan, green, magenta, red, blue, black.
    - Bar width BW = H_ACTIVE/8, integer division.
    - The bar index comes from a counter that increments every BW active pixels, saturates at 7 and resets at each line start.
    - The remainder pixels therefore fall in black. Division is not synthesised.
    - Colours are full-scale 8'hFF/8'h00 per component.
  - 1 checker: white if x[3]^y[3] is 0, else black (8x8 cells).
  - 2 gradient: R=x[7:0], G=y[7:0], B=frame_cnt[7:0].
  - 3 solid: the latched solid_rgb.
- Simultaneous events: the frame wrap, frame_cnt increment, mode latch and frame_start all occur together. rst_n takes priority over en, and en takes priority over everything else.

Optional Feature:
- Macro: DVI_TG_PATTERN_EN.
- Defined: the pattern logic and mode latch are built as specified.
- Undefined:
  - The pattern logic and mode latch are removed.
  - rgb = solid_rgb when de=1, else 0; solid_rgb is sampled combinationally into the output register, with no frame latch.
  - The mode input is ignored.
  - All timing, frame_cnt and frame_start behaviour is identical.

Test Plan:
1. Reset/defaults: hold rst_n=0 for 5 cycles with en=1, then release -> during reset hsync=vsync=1, de=0, rgb=0. On the 1st edge after release: x=0, y=0, de=1, frame_start=1, rgb=FFFFFF.
2. Default 640x480 timing -> de high 640 consecutive cycles per line. hsync low for exactly 96 cycles, x=656..751. Line period 800 cycles. vsync low for lines y=490..491 (1600 cycles). frame_start period 420000 cycles. frame_cnt=1 after the first wrap.
3. Small parameters H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 -> hsync high for x=18..20 and line period 24. Bars change every 2 pixels: x=0 gives FFFFFF, x=2 gives FFFF00, x=14 gives 000000.
4. Set mode=3 with solid_rgb=123456 at mid-frame (y=1) -> rgb stays in bars until the next frame_start, then becomes 123456 for all active pixels.
5. Drop en at x=5,y=2 for 10 cycles, then raise it -> outputs idle during the gap. The restart shows frame_start with x=y=0, and frame_cnt is unchanged by the abort.
6. Mode 2 in the 3rd frame (frame_cnt=2) -> pixel (7,3) has rgb=070302.

Source files
------------

// File: rtl/dvi_timing_pattern_gen.sv
// dvi_timing_pattern_gen
// Pixel-domain video timing generator with a built-in test-pattern source.
// It sits between the pixel PLL and the TMDS encoder. It produces sync, data
// enable, pixel coordinates, frame markers and 24-bit RGB. Every output is
// registered, so the values seen in cycle n+1 describe the counter position
// of cycle n, and all outputs stay aligned with one another.
//
// Ports:
//   pix_clk     in   1   pixel clock, the only clock
//   rst_n       in   1   synchronous active-low reset
//   en          in   1   run enable (0 = counters parked at (0,0), outputs idle)
//   mode        in   2   pattern: 0 bars, 1 checker, 2 gradient, 3 solid
//   solid_rgb   in  24   solid colour {R,G,B}
//   hsync       out  1   horizontal sync (asserted level HS_POL)
//   vsync       out  1   vertical sync (asserted level VS_POL)
//   de          out  1   active video
//   x, y        out CW   coordinates of the presented pixel, blanking included
//   frame_start out  1   one-cycle pulse with pixel (0,0)
//   frame_cnt   out 16   completed-frame counter, wraps modulo 2^16
//   rgb         out 24   pixel colour, 0 outside active video
//
// Build option: define DVI_TG_PATTERN_EN to build the pattern engine and the
// frame-boundary mode latch. Without it, rgb shows solid_rgb directly during
// active video and the mode input is ignored.

`default_nettype none

module dvi_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 12
) (
    input  logic          pix_clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic [15:0]   frame_cnt,
    output logic [23:0]   rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEGIN  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEGIN  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON     = (HS_POL != 0);
    localparam logic          VS_ON     = (VS_POL != 0);

    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic [CW-1:0] h_next_s;
    logic [CW-1:0] v_next_s;
    logic [15:0]   fcnt_r;
    logic          active_s;
    logic          hs_s;
    logic          vs_s;
    logic          origin_s;
    logic          h_last_s;
    logic          frame_last_s;
    logic [23:0]   pix_s;

    // Region decode and next-position arithmetic for the raster counters.
    always_comb begin
        active_s     = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
        hs_s         = ((h_cnt_r >= HS_BEGIN) && (h_cnt_r < HS_END)) ? HS_ON : ~HS_ON;
        vs_s         = ((v_cnt_r >= VS_BEGIN) && (v_cnt_r < VS_END)) ? VS_ON : ~VS_ON;
        origin_s     = (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
        h_last_s     = (h_cnt_r == H_LAST);
        frame_last_s = h_last_s && (v_cnt_r == V_LAST);
        h_next_s     = h_cnt_r + CNT_ONE;
        v_next_s     = v_cnt_r;
        if (h_last_s) begin
            h_next_s = CNT_ZERO;
            if (v_cnt_r == V_LAST) begin
                v_next_s = CNT_ZERO;
            end else begin
                v_next_s = v_cnt_r + CNT_ONE;
            end
        end else begin
            h_next_s = h_cnt_r + CNT_ONE;
        end
    end

    // Raster counters; parked at (0,0) while disabled so a restart begins a fresh frame.
    always_ff @(posedge pix_clk) begin
        if (!rst_n || !en) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else begin
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
        end
    end

    // Completed-frame count, bumped on the wrap from the last pixel back to (0,0).
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            fcnt_r <= 16'd0;
        end else if (en && frame_last_s) begin
            fcnt_r <= fcnt_r + 16'd1;
        end else begin
            fcnt_r <= fcnt_r;
        end
    end

`ifdef DVI_TG_PATTERN_EN
    localparam logic [CW-1:0] BAR_SUB_LAST = CW'((H_ACTIVE / 8) - 1);

    logic [CW-1:0] bar_sub_r;
    logic [2:0]    bar_idx_r;
    logic [1:0]    mode_r;
    logic [23:0]   solid_r;
    logic [1:0]    eff_mode_s;
    logic [23:0]   eff_solid_s;

    // Bar index for the current column: steps every H_ACTIVE/8 pixels, sticks at
    // 7 (black) so remainder pixels stay black, and restarts on every new line.
    always_ff @(posedge pix_clk) begin
        if (!rst_n || !en || h_last_s) begin
            bar_sub_r <= CNT_ZERO;
            bar_idx_r <= 3'd0;
        end else if (bar_sub_r == BAR_SUB_LAST) begin
            bar_sub_r <= CNT_ZERO;
            bar_idx_r <= (bar_idx_r == 3'd7) ? 3'd7 : (bar_idx_r + 3'd1);
        end else begin
            bar_sub_r <= bar_sub_r + CNT_ONE;
            bar_idx_r <= bar_idx_r;
        end
    end

    // Frame-boundary latch of the pattern selection.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            mode_r  <= 2'd0;
            solid_r <= 24'h000000;
        end else if (en && origin_s) begin
            mode_r  <= mode;
            solid_r <= solid_rgb;
        end else begin
            mode_r  <= mode_r;
            solid_r <= solid_r;
        end
    end

    // Pattern colour. Pixel (0,0) already uses the newly sampled selection so
    // the whole frame is drawn with a single mode.
    always_comb begin
        eff_mode_s  = origin_s ? mode : mode_r;
        eff_solid_s = origin_s ? solid_rgb : solid_r;
        case (eff_mode_s)
            // Bar colours in index order: R is on for 0,1,4,5; G for 0..3; B for even indices.
            2'd0:    pix_s = {{8{~bar_idx_r[1]}}, {8{~bar_idx_r[2]}}, {8{~bar_idx_r[0]}}};
            2'd1:    pix_s = (h_cnt_r[3] ^ v_cnt_r[3]) ? 24'h000000 : 24'hFFFFFF;
            2'd2:    pix_s = {h_cnt_r[7:0], v_cnt_r[7:0], fcnt_r[7:0]};
            2'd3:    pix_s = eff_solid_s;
            default: pix_s = 24'h000000;
        endcase
    end
`else
    logic unused_mode_s;

    // Plain colour source: the live solid colour with no frame latch.
    always_comb begin
        pix_s         = solid_rgb;
        unused_mode_s = ^mode;
    end
`endif

    // Output register stage: idle levels while in reset or disabled.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            x           <= CNT_ZERO;
            y           <= CNT_ZERO;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
            rgb         <= 24'h000000;
        end else if (!en) begin
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            x           <= CNT_ZERO;
            y           <= CNT_ZERO;
            frame_start <= 1'b0;
            frame_cnt   <= fcnt_r;
            rgb         <= 24'h000000;
        end else begin
            hsync       <= hs_s;
            vsync       <= vs_s;
            de          <= active_s;
            x           <= h_cnt_r;
            y           <= v_cnt_r;
            frame_start <= origin_s;
            frame_cnt   <= fcnt_r;
            rgb         <= active_s ? pix_s : 24'h000000;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dvi_timing_pattern_gen.sv
// Self-checking bench for dvi_timing_pattern_gen. A small-raster instance is
// compared cycle by cycle with a behavioural model computed from the raster
// rules; a default-parameter instance is checked on reset and on its first line.

`timescale 1ns/1ps

module tb_dvi_timing_pattern_gen;

    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 4,  S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;

    logic        s_hsync, s_vsync, s_de, s_frame_start;
    logic [11:0] s_x, s_y;
    logic [15:0] s_frame_cnt;
    logic [23:0] s_rgb;

    logic        b_hsync, b_vsync, b_de, b_frame_start;
    logic [11:0] b_x, b_y;
    logic [15:0] b_frame_cnt;
    logic [23:0] b_rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dvi_timing_pattern_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1), .VS_POL(0), .CW(12)
    ) u_dut_small (
        .pix_clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
        .frame_start(s_frame_start), .frame_cnt(s_frame_cnt), .rgb(s_rgb)
    );

    dvi_timing_pattern_gen u_dut_default (
        .pix_clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .x(b_x), .y(b_y),
        .frame_start(b_frame_start), .frame_cnt(b_frame_cnt), .rgb(b_rgb)
    );

    // ---------------- reference model for the small instance ----------------
    int          m_h, m_v, m_fc;
    logic        e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_x, e_y;
    logic [15:0] e_fc;
    logic [23:0] e_rgb;
    logic [67:0] s_bus, e_bus;
    logic        m_origin, m_active;

    assign s_bus    = {s_hsync, s_vsync, s_de, s_x, s_y, s_frame_start, s_frame_cnt, s_rgb};
    assign e_bus    = {e_hs, e_vs, e_de, e_x, e_y, e_fs, e_fc, e_rgb};
    assign m_origin = (m_h == 0) && (m_v == 0);
    assign m_active = (m_h < S_HA) && (m_v < S_VA);

`ifdef DVI_TG_PATTERN_EN
    localparam logic [23:0] BAR_COLOUR [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [1:0]  m_mode;
    logic [23:0] m_solid;

    function automatic logic [23:0] pat(int h, int v, logic [1:0] md, logic [23:0] sd, int fc);
        int bar;
        if (h >= S_HA || v >= S_VA) return 24'h000000;
        case (md)
            2'd0: begin
                bar = h / (S_HA / 8);
                if (bar > 7) bar = 7;
                return BAR_COLOUR[bar];
            end
            2'd1:    return ((((h / 8) + (v / 8)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
            2'd2:    return 24'(((h % 256) * 65536) + ((v % 256) * 256) + (fc % 256));
            default: return sd;
        endcase
    endfunction
`endif

    always @(posedge clk) begin
        if (!rst_n || !en) begin
            m_h   <= 0;
            m_v   <= 0;
            e_hs  <= 1'b0;
            e_vs  <= 1'b1;
            e_de  <= 1'b0;
            e_x   <= 12'd0;
            e_y   <= 12'd0;
            e_fs  <= 1'b0;
            e_rgb <= 24'h000000;
            if (!rst_n) begin
                m_fc <= 0;
                e_fc <= 16'd0;
`ifdef DVI_TG_PATTERN_EN
                m_mode  <= 2'd0;
                m_solid <= 24'h000000;
`endif
            end else begin
                e_fc <= 16'(m_fc);
            end
        end else begin
            e_hs <= (m_h >= S_HA + S_HF) && (m_h < S_HA + S_HF + S_HS);
            e_vs <= !((m_v >= S_VA + S_VF) && (m_v < S_VA + S_VF + S_VS));
            e_de <= m_active;
            e_x  <= 12'(m_h);
            e_y  <= 12'(m_v);
            e_fs <= m_origin;
            e_fc <= 16'(m_fc);
`ifdef DVI_TG_PATTERN_EN
            e_rgb <= pat(m_h, m_v, m_origin ? mode : m_mode, m_origin ? solid_rgb : m_solid, m_fc);
            if (m_origin) begin
                m_mode  <= mode;
                m_solid <= solid_rgb;
            end
`else
            e_rgb <= m_active ? solid_rgb : 24'h000000;
`endif
            if (m_h == S_HT - 1) begin
                m_h <= 0;
                if (m_v == S_VT - 1) begin
                    m_v  <= 0;
                    m_fc <= (m_fc + 1) % 65536;
                end else begin
                    m_v <= m_v + 1;
                end
            end else begin
                m_h <= m_h + 1;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; solid_rgb = 24'hFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({b_hsync, b_vsync, b_de, b_rgb} !== {1'b1, 1'b1, 1'b0, 24'h000000}) begin
                errors++;
                $display("FAIL reset_idle hs=%b vs=%b de=%b rgb=%h exp 1 1 0 000000", b_hsync, b_vsync, b_de, b_rgb);
            end
            checks++;
            if (s_bus !== e_bus) begin
                errors++;
                $display("FAIL reset_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_x, b_y, b_de, b_frame_start, b_rgb} !== {12'd0, 12'd0, 1'b1, 1'b1, 24'hFFFFFF}) begin
            errors++;
            $display("FAIL first_pixel x=%0d y=%0d de=%b fs=%b rgb=%h exp 0 0 1 1 FFFFFF", b_x, b_y, b_de, b_frame_start, b_rgb);
        end
    endtask

    task automatic test_default_line;
        int de_n = 0, hs_n = 0, hs_first = -1, hs_last = -1;
        for (int c = 0; c < 800; c++) begin
            if (b_de) de_n++;
            if (!b_hsync) begin
                if (hs_first < 0) hs_first = int'(b_x);
                hs_last = int'(b_x);
                hs_n++;
            end
            checks++;
            if (int'(b_x) != c || b_y !== 12'd0) begin
                errors++;
                $display("FAIL default_sweep x=%0d y=%0d exp %0d 0", b_x, b_y, c);
            end
            checks++;
            if (s_bus !== e_bus) begin
                errors++;
                $display("FAIL default_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus);
            end
            @(negedge clk);
        end
        checks++;
        if (de_n != 640) begin errors++; $display("FAIL default_de_count got %0d exp 640", de_n); end
        checks++;
        if (hs_n != 96 || hs_first != 656 || hs_last != 751) begin
            errors++;
            $display("FAIL default_hsync n=%0d first=%0d last=%0d exp 96 656 751", hs_n, hs_first, hs_last);
        end
        checks++;
        if ({b_x, b_y} !== {12'd0, 12'd1}) begin
            errors++;
            $display("FAIL default_line_period x=%0d y=%0d exp 0 1", b_x, b_y);
        end
    endtask

    task automatic test_small_timing;
        int n = 0;
        while (!s_frame_start && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (!s_frame_start) begin errors++; $display("FAIL small_sync_timeout got fs=%b exp 1", s_frame_start); end
        for (int c = 0; c < S_HT; c++) begin
            checks++;
            if (int'(s_x) != c || s_hsync !== (c >= 18 && c <= 20)) begin
                errors++;
                $display("FAIL small_hsync x=%0d hs=%b exp x=%0d hs=%b", s_x, s_hsync, c, (c >= 18 && c <= 20));
            end
            if (c == 0 || c == 2 || c == 14) begin
                checks++;
`ifdef DVI_TG_PATTERN_EN
                if (s_rgb !== ((c == 0) ? 24'hFFFFFF : (c == 2) ? 24'hFFFF00 : 24'h000000)) begin
`else
                if (s_rgb !== 24'hFFFFFF) begin
`endif
                    errors++;
                    $display("FAIL small_bars x=%0d rgb=%h", c, s_rgb);
                end
            end
            checks++;
            if (s_bus !== e_bus) begin errors++; $display("FAIL small_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus); end
            @(negedge clk);
        end
        checks++;
        if ({s_x, s_y} !== {12'd0, 12'd1}) begin
            errors++;
            $display("FAIL small_line_period x=%0d y=%0d exp 0 1", s_x, s_y);
        end
    endtask

    task automatic test_mode_latch;
        int n = 0, seen = 0;
        while (!(s_y == 12'd1 && s_x == 12'd0) && n < 400) begin @(negedge clk); n++; end
        mode = 2'd3; solid_rgb = 24'h123456;
        n = 0;
        @(negedge clk);
        while (!s_frame_start && n < 400) begin
            checks++;
            if (s_bus !== e_bus) begin errors++; $display("FAIL latch_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus); end
            if (s_x == 12'd2 && s_y == 12'd2) begin
                seen++;
                checks++;
`ifdef DVI_TG_PATTERN_EN
                if (s_rgb !== 24'hFFFF00) begin
`else
                if (s_rgb !== 24'h123456) begin
`endif
                    errors++;
                    $display("FAIL latch_old_frame rgb=%h at (2,2)", s_rgb);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (seen != 1 || !s_frame_start) begin errors++; $display("FAIL latch_sync seen=%0d fs=%b exp 1 1", seen, s_frame_start); end
        for (int c = 0; c < S_HT * S_VT; c++) begin
            if (s_de) begin
                checks++;
                if (s_rgb !== 24'h123456) begin errors++; $display("FAIL latch_new_frame rgb=%h exp 123456", s_rgb); end
            end
            checks++;
            if (s_bus !== e_bus) begin errors++; $display("FAIL latch_model2 t=%0t dut=%h ref=%h", $time, s_bus, e_bus); end
            @(negedge clk);
        end
    endtask

    task automatic test_en_gap;
        int n = 0;
        logic [15:0] saved;
        while (!(s_x == 12'd5 && s_y == 12'd2) && n < 400) begin @(negedge clk); n++; end
        saved = s_frame_cnt;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (s_bus !== {1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, saved, 24'h000000}) begin
                errors++;
                $display("FAIL en_gap_idle dut=%h frame_cnt_exp=%0d", s_bus, saved);
            end
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_frame_start, s_x, s_y, s_frame_cnt} !== {1'b1, 12'd0, 12'd0, saved}) begin
            errors++;
            $display("FAIL en_restart fs=%b x=%0d y=%0d fc=%0d exp 1 0 0 %0d", s_frame_start, s_x, s_y, s_frame_cnt, saved);
        end
        checks++;
        if (s_bus !== e_bus) begin errors++; $display("FAIL en_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus); end
    endtask

    task automatic test_gradient;
        int n = 0;
        rst_n = 1'b0; en = 1'b1; mode = 2'd2; solid_rgb = 24'($urandom);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        while (!(s_frame_cnt == 16'd2 && s_x == 12'd7 && s_y == 12'd3) && n < 600) begin
            checks++;
            if (s_bus !== e_bus) begin errors++; $display("FAIL grad_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus); end
            @(negedge clk);
            n++;
        end
        checks++;
`ifdef DVI_TG_PATTERN_EN
        if (n >= 600 || s_rgb !== 24'h070302) begin
`else
        if (n >= 600 || s_rgb !== solid_rgb) begin
`endif
            errors++;
            $display("FAIL gradient_pixel cycles=%0d rgb=%h", n, s_rgb);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (s_bus !== e_bus) begin errors++; $display("FAIL random_model t=%0t dut=%h ref=%h", $time, s_bus, e_bus); end
            rst_n = ($urandom_range(0, 199) != 0);
            if (en) en = ($urandom_range(0, 99) >= 2);
            else    en = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) solid_rgb = 24'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; solid_rgb = 24'hFFFFFF;
        test_reset();
        test_default_line();
        test_small_timing();
        test_mode_latch();
        test_en_gap();
        test_gradient();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
